// File: rtl/fuel_pump_pkg.sv
// rtl/fuel_pump_pkg.sv - shared types and default parameters for the fuel-pump interlock
package fuel_pump_pkg;

    // Pump interlock states; ON is the only state in which the relay is driven.
    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } pump_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1;

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - single-bit synchronizer followed by a consecutive-cycle debounce filter
module sync_debounce
    import fuel_pump_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetN,
    input  logic din_i,
    output logic level_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Shift the raw asynchronous level through the metastability chain.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    // Accept a new level in the cycle where it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; the accepted level is forwarded combinationally so a
    // one-cycle filter adds no latency beyond the synchronizer.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_lvl != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Hold the filtered level and the run-length of disagreement.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_d;

endmodule

// File: rtl/fuel_pump_logic.sv
// rtl/fuel_pump_logic.sv - anti-theft interlock that powers the fuel pump after ignition, brake and hidden switch coincide
module fuel_pump_logic
    import fuel_pump_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetN,
    input  logic ignition,
    input  logic brake,
    input  logic hidden,
    output logic fuelPumpPower
);

    logic        ign, brk, hid;
    pump_state_e state_q, state_d;

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ign (
        .clock   (clock),
        .resetN  (resetN),
        .din_i   (ignition),
        .level_o (ign)
    );

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_brk (
        .clock   (clock),
        .resetN  (resetN),
        .din_i   (brake),
        .level_o (brk)
    );

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hid (
        .clock   (clock),
        .resetN  (resetN),
        .din_i   (hidden),
        .level_o (hid)
    );

    // Arm only on a full coincidence; once armed, only ignition-off disarms,
    // and ignition low always wins over brake/hidden.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  if (ign && brk && hid) state_d = ST_ON;
            ST_ON:   if (!ign)              state_d = ST_OFF;
            default:                        state_d = ST_OFF;
        endcase
    end

    // Interlock state register; reset forces the pump off immediately.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign fuelPumpPower = (state_q == ST_ON);

endmodule

// File: tb/tb_fuel_pump_logic.sv
// tb/tb_fuel_pump_logic.sv - self-checking bench for fuel_pump_logic with directed and random stimulus
module tb_fuel_pump_logic;

    localparam int LAT = 2;
    localparam int HN  = 256;

    logic clock = 1'b0;
    logic resetN;
    logic ignition;
    logic brake;
    logic hidden;
    logic fuelPumpPower;

    int n_checks = 0;
    int n_fail   = 0;

    fuel_pump_logic dut (
        .clock         (clock),
        .resetN        (resetN),
        .ignition      (ignition),
        .brake         (brake),
        .hidden        (hidden),
        .fuelPumpPower (fuelPumpPower)
    );

    always #4 clock = ~clock;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0b expected=%0b at %0t", tag, got, exp, $time);
        end
    endtask

    // Interlock rule: ignition off disarms; armed stays armed; otherwise arm on coincidence.
    function automatic logic pump_rule(input logic on, input logic [2:0] s);
        if (!s[2]) return 1'b0;
        if (on)    return 1'b1;
        return s[1] & s[0];
    endfunction

    // Reference: the rule sees the raw switch levels sampled LAT edges earlier
    // (zero before enough edges have passed since reset).
    logic [2:0] samp [0:HN-1];
    int         since_rst = 0;
    logic       exp_on = 1'b0;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            since_rst <= 0;
            exp_on    <= 1'b0;
        end else begin
            exp_on <= pump_rule(exp_on, (since_rst >= LAT) ? samp[(since_rst - LAT) % HN] : 3'b000);
            samp[since_rst % HN] <= {ignition, brake, hidden};
            since_rst <= since_rst + 1;
        end
    end

    always @(negedge clock) check_eq("track", fuelPumpPower, exp_on);

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        resetN   = 1'b0;
        ignition = 1'b0;
        brake    = 1'b0;
        hidden   = 1'b0;
        #2 resetN = 1'b1;
        check_eq("reset_state", fuelPumpPower, 1'b0);

        // Arming sequence on absolute times
        #8  ignition = 1'b1;                          // 10
        #12 brake    = 1'b1;                          // 22
        #12 hidden   = 1'b1;                          // 34
        #12 hidden   = 1'b0;                          // 46
        #4  check_eq("arm_before", fuelPumpPower, 1'b0); // 50
        #4  check_eq("arm_on", fuelPumpPower, 1'b1);     // 54
        #4  brake    = 1'b0;                          // 58
        #12 ignition = 1'b0;                          // 70
        #20 check_eq("arm_hold", fuelPumpPower, 1'b1);   // 90
        #4  check_eq("arm_off", fuelPumpPower, 1'b0);    // 94

        // No ignition
        cyc(1); brake = 1'b1;
        cyc(2); hidden = 1'b1;
        cyc(3); hidden = 1'b0;
        cyc(4); check_eq("no_ign", fuelPumpPower, 1'b0);
        brake = 1'b0;

        // No brake, then brake after hidden released
        cyc(1); ignition = 1'b1;
        cyc(2); hidden = 1'b1;
        cyc(3); hidden = 1'b0;
        cyc(1); brake = 1'b1;
        cyc(4); check_eq("no_brk", fuelPumpPower, 1'b0);

        // Simultaneous: drop ignition while brake and hidden are high, then re-arm
        hidden = 1'b1;
        cyc(4); check_eq("sim_on", fuelPumpPower, 1'b1);
        ignition = 1'b0;
        cyc(4); check_eq("sim_off", fuelPumpPower, 1'b0);
        ignition = 1'b1;
        cyc(4); check_eq("re_arm", fuelPumpPower, 1'b1);

        // Reset mid-ON
        @(negedge clock); #2 resetN = 1'b0;
        #1 check_eq("rst_async", fuelPumpPower, 1'b0);
        brake  = 1'b0;
        hidden = 1'b0;
        cyc(2); check_eq("rst_low", fuelPumpPower, 1'b0);
        resetN = 1'b1;
        cyc(5); check_eq("rst_after", fuelPumpPower, 1'b0);

        // Reset with all inputs high
        resetN   = 1'b0;
        ignition = 1'b1;
        brake    = 1'b1;
        hidden   = 1'b1;
        cyc(3); check_eq("rst_all1", fuelPumpPower, 1'b0);
        brake  = 1'b0;
        hidden = 1'b0;
        cyc(1); resetN = 1'b1;
        cyc(4); check_eq("rst_rel", fuelPumpPower, 1'b0);

        // Randomized switch activity with occasional asynchronous resets
        repeat (600) begin
            cyc(1);
            if ($urandom_range(0, 3) == 0) ignition = ~ignition;
            if ($urandom_range(0, 2) == 0) brake    = ~brake;
            if ($urandom_range(0, 2) == 0) hidden   = ~hidden;
            if ($urandom_range(0, 79) == 0) begin
                #1 resetN = 1'b0;
                #1 check_eq("rnd_rst", fuelPumpPower, 1'b0);
                #2 resetN = 1'b1;
            end
        end

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
